// File: rtl/ioblock_array.sv
// ioblock_array: NPIN-pad I/O tile whose per-pin mode comes from a serially loaded, daisy-chainable config chain.
// Optional macro IOB_OUTREG_EN adds per-pin output/TS flops, selected by each pin's OUTREG bit.
module ioblock_array #(
    parameter int NPIN = 4
) (
    input  logic            IOCLK,
    input  logic            RST,
    inout  wire [NPIN-1:0]  PIN,
    input  logic [NPIN-1:0] TS,
    input  logic [NPIN-1:0] OUT,
    output logic [NPIN-1:0] IN,
    input  logic            CFG_EN,
    input  logic            CFG_DIN,
    output logic            CFG_DOUT,
    output logic            CFG_BUSY,
    output logic            CFG_DONE
);
    localparam int CFGW = 4;
    localparam int L    = CFGW * NPIN;
    localparam int CW   = $clog2(L + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(L - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [L-1:0]    shadow;
    logic [L-1:0]    active;
    logic [NPIN-1:0] dreg;
    logic [NPIN-1:0] odata;
    logic [NPIN-1:0] tdata;
    logic [NPIN-1:0] drive;

    // The shadow keeps shifting even while a tile downstream is loading, so
    // CFG_DOUT always carries the bit received L accepted shifts earlier.
    always_ff @(posedge IOCLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            shadow   <= '0;
            active   <= '0;
            CFG_BUSY <= 1'b0;
            CFG_DONE <= 1'b0;
        end else begin
            CFG_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (CFG_EN) begin
                        shadow   <= {CFG_DIN, shadow[L-1:1]};
                        cnt      <= CW'(1);
                        CFG_BUSY <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (CFG_EN) begin
                        shadow <= {CFG_DIN, shadow[L-1:1]};
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST_IDX) begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    active   <= shadow;
                    CFG_DONE <= 1'b1;
                    CFG_BUSY <= 1'b0;
                    cnt      <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign CFG_DOUT = shadow[0];

    always_ff @(posedge IOCLK) begin
        if (RST) begin
            dreg <= '0;
        end else begin
            dreg <= PIN;
        end
    end

`ifdef IOB_OUTREG_EN
    logic [NPIN-1:0] oreg;
    logic [NPIN-1:0] treg;

    always_ff @(posedge IOCLK) begin
        if (RST) begin
            oreg <= '0;
            treg <= '0;
        end else begin
            oreg <= OUT;
            treg <= TS;
        end
    end

    for (genvar i = 0; i < NPIN; i++) begin : g_outsel
        assign odata[i] = active[CFGW*i+3] ? oreg[i] : OUT[i];
        assign tdata[i] = active[CFGW*i+3] ? treg[i] : TS[i];
    end
`else
    // OUTREG bits still occupy the chain so bitstreams stay interchangeable.
    logic [NPIN-1:0] unused_outreg;

    for (genvar i = 0; i < NPIN; i++) begin : g_outsel
        assign unused_outreg[i] = active[CFGW*i+3];
    end

    assign odata = OUT;
    assign tdata = TS;
`endif

    for (genvar i = 0; i < NPIN; i++) begin : g_pin
        logic [1:0] tsmux;
        assign tsmux    = active[CFGW*i +: 2];
        assign drive[i] = (tsmux == 2'b01) ? tdata[i] : tsmux[1];
        assign PIN[i]   = drive[i] ? odata[i] : 1'bz;
        assign IN[i]    = active[CFGW*i+2] ? dreg[i] : PIN[i];
    end

endmodule

// File: tb/tb_ioblock_array.sv
// Bench for ioblock_array: directed config loads with a queue model of the daisy-chain output.
module tb_ioblock_array;
    localparam int NPIN = 4;
    localparam int L    = 16;

    logic       IOCLK = 1'b0;
    logic       RST;
    logic       CFG_EN;
    logic       CFG_DIN;
    logic [3:0] TS;
    logic [3:0] OUT;
    logic [3:0] ext_en;
    logic [3:0] ext_val;
    wire  [3:0] pad;
    wire  [3:0] IN;
    wire        CFG_DOUT;
    wire        CFG_BUSY;
    wire        CFG_DONE;

    int   checks   = 0;
    int   failures = 0;
    logic dq[$];

    always #5 IOCLK = ~IOCLK;

    for (genvar i = 0; i < NPIN; i++) begin : g_ext
        assign pad[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end

    ioblock_array #(.NPIN(NPIN)) dut (
        .IOCLK    (IOCLK),
        .RST      (RST),
        .PIN      (pad),
        .TS       (TS),
        .OUT      (OUT),
        .IN       (IN),
        .CFG_EN   (CFG_EN),
        .CFG_DIN  (CFG_DIN),
        .CFG_DOUT (CFG_DOUT),
        .CFG_BUSY (CFG_BUSY),
        .CFG_DONE (CFG_DONE)
    );

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge IOCLK);
        #1;
    endtask

    // Model of the shadow chain as seen from CFG_DOUT: index 0 is the bit now on CFG_DOUT.
    task automatic resetQueue();
        dq.delete();
        repeat (L) dq.push_back(1'b0);
    endtask

    task automatic applyStimulus(input logic b);
        logic expOut;
        CFG_EN  = 1'b1;
        CFG_DIN = b;
        expOut  = dq.pop_front();
        checkOutput("cfg_dout", CFG_DOUT, expOut);
        dq.push_back(b);
        tick();
    endtask

    task automatic loadConfig(input logic [15:0] cfg, input int pauseAt);
        for (int i = 0; i < L; i++) begin
            applyStimulus(cfg[i]);
            if (i + 1 == pauseAt) begin
                CFG_EN = 1'b0;
                repeat (5) begin
                    tick();
                    checkOutput("busy_pause", CFG_BUSY, 1'b1);
                    checkOutput("done_pause", CFG_DONE, 1'b0);
                end
            end
        end
        CFG_EN = 1'b0;
        checkOutput("busy_commit", CFG_BUSY, 1'b1);
        checkOutput("done_early", CFG_DONE, 1'b0);
        tick();
        checkOutput("done_pulse", CFG_DONE, 1'b1);
        checkOutput("busy_after", CFG_BUSY, 1'b0);
        tick();
        checkOutput("done_once", CFG_DONE, 1'b0);
    endtask

    initial begin
        RST     = 1'b1;
        CFG_EN  = 1'b0;
        CFG_DIN = 1'b0;
        TS      = 4'b0000;
        OUT     = 4'b0000;
        ext_en  = 4'b0000;
        ext_val = 4'b0000;
        resetQueue();
        tick();
        tick();
        checkOutput("rst_pads_z", pad === 4'bzzzz, 1'b1);
        checkOutput("rst_busy", CFG_BUSY, 1'b0);
        checkOutput("rst_done", CFG_DONE, 1'b0);
        checkOutput("rst_dout", CFG_DOUT, 1'b0);
        RST = 1'b0;

        // pin0 always drives, pin1 follows TS, pins 2/3 float
        OUT = 4'b1111;
        TS  = 4'b0000;
        loadConfig(16'h0012, 0);
        checkOutput("p0_drive", pad[0], 1'b1);
        checkOutput("p1_z", pad[1] === 1'bz, 1'b1);
        checkOutput("p2_z", pad[2] === 1'bz, 1'b1);
        checkOutput("p3_z", pad[3] === 1'bz, 1'b1);
        checkOutput("in0_comb", IN[0], 1'b1);
        TS[1] = 1'b1;
        #1;
        checkOutput("p1_ts_on", pad[1], 1'b1);
        OUT[0] = 1'b0;
        #1;
        checkOutput("p0_comb_out", pad[0], 1'b0);

        // paused load of a swapped config
        OUT = 4'b1111;
        TS  = 4'b0000;
        loadConfig(16'h0021, 7);
        checkOutput("pause_p0_z", pad[0] === 1'bz, 1'b1);
        checkOutput("pause_p1_drive", pad[1], 1'b1);
        TS[0] = 1'b1;
        #1;
        checkOutput("pause_p0_ts_on", pad[0], 1'b1);

        // pin2 registered input, pin3 combinational, both pads externally driven
        TS = 4'b0000;
        loadConfig(16'h0400, 0);
        ext_en  = 4'b1100;
        ext_val = 4'b0000;
        tick();
        checkOutput("in2_low", IN[2], 1'b0);
        checkOutput("in3_low", IN[3], 1'b0);
        ext_val = 4'b1100;
        #1;
        checkOutput("in3_immediate", IN[3], 1'b1);
        checkOutput("in2_not_yet", IN[2], 1'b0);
        tick();
        checkOutput("in2_registered", IN[2], 1'b1);
        ext_val = 4'b0000;
        #1;
        checkOutput("in3_fall", IN[3], 1'b0);
        checkOutput("in2_hold", IN[2], 1'b1);
        tick();
        checkOutput("in2_fall", IN[2], 1'b0);
        ext_en = 4'b0000;

        // reset after 10 bits abandons the load and clears the active config
        OUT = 4'b1111;
        TS  = 4'b1111;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1);
        CFG_EN = 1'b0;
        RST    = 1'b1;
        tick();
        RST = 1'b0;
        resetQueue();
        checkOutput("mid_rst_pads_z", pad === 4'bzzzz, 1'b1);
        checkOutput("mid_rst_busy", CFG_BUSY, 1'b0);
        checkOutput("mid_rst_dout", CFG_DOUT, 1'b0);
        repeat (3) begin
            tick();
            checkOutput("mid_rst_no_done", CFG_DONE, 1'b0);
            checkOutput("mid_rst_still_z", pad === 4'bzzzz, 1'b1);
        end
        loadConfig(16'h0012, 0);
        checkOutput("reload_p0", pad[0], 1'b1);
        checkOutput("reload_p1", pad[1], 1'b1);

        // pin0 always-drive with OUTREG set
        TS  = 4'b0000;
        OUT = 4'b1111;
        loadConfig(16'h000A, 0);
        checkOutput("oreg_p0_high", pad[0], 1'b1);
        OUT[0] = 1'b0;
        #1;
`ifdef IOB_OUTREG_EN
        checkOutput("oreg_p0_hold", pad[0], 1'b1);
        tick();
        checkOutput("oreg_p0_fall", pad[0], 1'b0);
        OUT[0] = 1'b1;
        #1;
        checkOutput("oreg_p0_hold2", pad[0], 1'b0);
        tick();
        checkOutput("oreg_p0_rise", pad[0], 1'b1);
`else
        checkOutput("oreg_ignored_fall", pad[0], 1'b0);
        OUT[0] = 1'b1;
        #1;
        checkOutput("oreg_ignored_rise", pad[0], 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
